clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
Measures an incoming slow, asynchronous clock-like signal against the system clock, such as a divided clock or any low-rate square wave. The block is armed by a start pulse. It reports period and high time in system-clock cycles through a valid/ready result interface. It sits at the consuming end of the divider chain and is used for on-chip checks of divide ratios and duty cycle.

Parameters:
CNT_W, 24, width of the period and high-time counters and results
SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2)
DGL_CYCLES, 3, deglitch stability length in clk cycles (used only with SIG_DEGLITCH_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sig_in  input  1  asynchronous signal to measure
start  input  1  single-cycle request to begin one measurement
busy  output  1  high from accepted start until the result is accepted
meas_valid  output  1  result available
meas_ready  input  1  consumer accepts the result
period  output  CNT_W  clk cycles between two consecutive rising edges
high_time  output  CNT_W  clk cycles from a rising edge to the following falling edge
overflow  output  1  measurement aborted because the counter saturated

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, meas_valid=0, period=0, high_time=0, overflow=0, counter=0, synchronizer flops=0.
- sig_in passes through SYNC_STAGES flops, then a history flop. rise = sync & ~hist; fall = ~sync & hist.
- Both edges see identical latency, so differences between edges are exact.
- FSM:
  - IDLE: start=1 -> ARM, busy=1, cnt=0, overflow=0.
  - ARM: wait for rise. On rise -> MEASURE with cnt=1. Otherwise cnt increments. If cnt reaches 2^CNT_W-1 -> HOLD with overflow=1, period=0, high_time=0.
  - MEASURE: cnt increments every cycle.
    - On fall: high_time <= cnt.
    - On rise: period <= cnt, then -> HOLD.
    - If cnt reaches 2^CNT_W-1 with no rise: period <= all ones, overflow=1, -> HOLD. high_time keeps its captured value, or 0 if no fall was seen.
  - HOLD: meas_valid=1. period, high_time and overflow stay stable. When meas_valid & meas_ready -> IDLE on the next edge, with meas_valid=0 and busy=0.
- Counting rule: with a rise detected at cycle t0, cnt equals k at cycle t0+k. For a square wave of half-period N clk: period=2N, high_time=N.
- high_time is cleared to 0 on entering ARM. If no fall occurs before the terminating rise, high_time reads 0.
- start is ignored whenever busy=1. start and meas_ready handshaking in the same cycle in HOLD: the handshake completes and start is ignored; the next start is needed in IDLE.
- Result registers update only at the capture points above. They are never cleared by the handshake.
- Reset asserted mid-measurement aborts immediately and returns all outputs to reset values. No partial result is emitted.
- Minimum measurable half-period: SYNC_STAGES+1 clk. Shorter pulses may be missed; this is unspecified but must not hang the FSM.

Optional Feature:
SIG_DEGLITCH_EN
- Defined: a deglitch filter sits between the synchronizer and the edge detector. The filtered level changes only after the synchronized level has held its new value for DGL_CYCLES consecutive clk. Shorter pulses are discarded. Added latency is identical for both edges, so period and high_time are unchanged for clean inputs.
- Undefined: no filter; the edge detector reads the synchronizer output directly, and DGL_CYCLES is unused.

Test Plan:
- Square wave sig_in with half-period 4 clk (toggle every 4 cycles), start pulse -> meas_valid rises; period=8, high_time=4, overflow=0; busy falls the cycle after meas_ready.
- Duty test, high 3 / low 7 clk, repeating -> period=10, high_time=3.
- CNT_W=8, sig_in held 0, start -> after 255 cycles in ARM: meas_valid=1, overflow=1, period=0, high_time=0. Repeat with sig_in rising once then held high: overflow=1, period=255, high_time=0.
- Backpressure: meas_ready low for 20 cycles in HOLD while sig_in keeps toggling -> period and high_time unchanged and meas_valid held. A start pulse during HOLD has no effect.
- Assert rst_n=0 mid-MEASURE for 1 cycle, asynchronously to clk -> busy, meas_valid and outputs are 0 immediately. A new start then measures correctly (period=8 for half-period 4).
- SIG_DEGLITCH_EN, DGL_CYCLES=3: half-period 10 square wave with 1-clk and 2-clk glitches injected inside the high phase -> period=20, high_time=10. Without the macro, the same stimulus gives high_time shorter than 10.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow asynchronous
// signal in system-clock cycles. A start pulse arms one measurement, and the
// result is returned over a valid/ready handshake.
// Optional build macro SIG_DEGLITCH_EN inserts a DGL_CYCLES stability filter
// between the synchronizer and the edge detector.
module clk_period_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int DGL_CYCLES  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  // The synchronizer needs at least two flops, so smaller values are clamped.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SYNC_N-1:0] sync_q;
  logic              lvl;
  logic              hist;
  logic              rise;
  logic              fall;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_full;

  // Bring sig_in into the clk domain through a plain flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_N-2:0], sig_in};
  end

`ifdef SIG_DEGLITCH_EN
  localparam int DGL_N = (DGL_CYCLES < 1) ? 1 : DGL_CYCLES;
  localparam int DGL_W = $clog2(DGL_N + 1);
  localparam logic [DGL_W-1:0] DGL_LAST = DGL_W'(DGL_N - 1);

  logic [DGL_W-1:0] dgl_cnt;
  logic             filt;

  // Follow the synchronized level only after it has disagreed with the
  // filtered level for DGL_N consecutive cycles. Both edges get the same delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= 1'b0;
      dgl_cnt <= '0;
    end else if (sync_q[SYNC_N-1] == filt) begin
      dgl_cnt <= '0;
    end else if (dgl_cnt == DGL_LAST) begin
      filt    <= sync_q[SYNC_N-1];
      dgl_cnt <= '0;
    end else begin
      dgl_cnt <= dgl_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync_q[SYNC_N-1];
`endif

  // Keep the previous level so rise and fall have identical latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b0;
    else        hist <= lvl;
  end

  assign rise       = lvl & ~hist;
  assign fall       = ~lvl & hist;
  assign cnt_full   = (cnt == CNT_MAX);
  assign busy       = (state != IDLE);
  assign meas_valid = (state == HOLD);

  // Register the measurement state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. In ARM, a rise takes priority over saturation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM: begin
        if (rise)          state_nxt = MEASURE;
        else if (cnt_full) state_nxt = HOLD;
      end
      MEASURE: if (rise || cnt_full) state_nxt = HOLD;
      HOLD:    if (meas_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter and result capture. cnt is 1 on the cycle after the starting rise,
  // so the count at a later edge equals the distance in clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            overflow  <= 1'b0;
            high_time <= '0;
          end
        end
        ARM: begin
          if (rise) begin
            cnt <= CNT_W'(1);
          end else if (cnt_full) begin
            overflow  <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (fall) high_time <= cnt;
          if (rise) begin
            period <= cnt;
          end else if (cnt_full) begin
            period   <= CNT_MAX;
            overflow <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed bench for clk_period_meter (CNT_W=8 so the
// saturation cases are short). It checks the SIG_DEGLITCH_EN build too.
module tb_clk_period_meter;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in;
  logic             start = 1'b0;
  logic             meas_ready = 1'b0;
  logic             busy;
  logic             meas_valid;
  logic             overflow;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  int n_chk = 0;
  int n_err = 0;

  // Waveform generator state. The generator writes cyc and gen_sig.
  // The main sequence writes the rest.
  int   cyc = 0;
  int   cyc0 = 0;
  int   hi_len = 4;
  int   lo_len = 4;
  bit   glitch_on = 1'b0;
  bit   gen_on = 1'b0;
  logic gen_sig = 1'b0;
  logic lvl_sig = 1'b0;

  assign sig_in = gen_on ? gen_sig : lvl_sig;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .DGL_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .period    (period),
    .high_time (high_time),
    .overflow  (overflow)
  );

  // Square wave with optional low glitches at phases 3 (1 clk) and 6-7 (2 clk).
  initial begin
    forever begin
      int ph;
      @(posedge clk);
      #2;
      cyc = cyc + 1;
      ph = (cyc - cyc0) % (hi_len + lo_len);
      gen_sig = (ph < hi_len);
      if (glitch_on && (ph == 3 || ph == 6 || ph == 7)) gen_sig = 1'b0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!meas_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk_eq({tag, "_valid"}, {31'd0, meas_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    chk_eq({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk_eq({tag, "_valid_off"}, {31'd0, meas_valid}, 32'd0);
  endtask

  // Return the input to a settled low, then start a wave at phase 0.
  task automatic start_wave(input int hi, input int lo, input bit glitch);
    gen_on = 1'b0;
    lvl_sig = 1'b0;
    repeat (6) tick();
    hi_len = hi;
    lo_len = lo;
    glitch_on = glitch;
    cyc0 = cyc + 1;
    gen_on = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_valid", {31'd0, meas_valid}, 32'd0);
    chk_eq("rst_period", {24'd0, period}, 32'd0);
    chk_eq("rst_high", {24'd0, high_time}, 32'd0);
    chk_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Square wave with half-period 4
    start_wave(4, 4, 1'b0);
    do_start();
    chk_eq("sq4_busy_on", {31'd0, busy}, 32'd1);
    wait_valid("sq4", 60);
    chk_eq("sq4_period", {24'd0, period}, 32'd8);
    chk_eq("sq4_high", {24'd0, high_time}, 32'd4);
    chk_eq("sq4_ovf", {31'd0, overflow}, 32'd0);
    chk_eq("sq4_busy_hold", {31'd0, busy}, 32'd1);
    handshake("sq4");

    // Duty cycle: high 3, low 7
    start_wave(3, 7, 1'b0);
    do_start();
    wait_valid("duty", 80);
    chk_eq("duty_period", {24'd0, period}, 32'd10);
    chk_eq("duty_high", {24'd0, high_time}, 32'd3);
    chk_eq("duty_ovf", {31'd0, overflow}, 32'd0);
    handshake("duty");

    // No rise at all: saturates in ARM
    gen_on = 1'b0;
    lvl_sig = 1'b0;
    repeat (6) tick();
    do_start();
    wait_valid("ovf_arm", 300);
    chk_eq("ovf_arm_ovf", {31'd0, overflow}, 32'd1);
    chk_eq("ovf_arm_period", {24'd0, period}, 32'd0);
    chk_eq("ovf_arm_high", {24'd0, high_time}, 32'd0);
    handshake("ovf_arm");

    // One rise and then held high: saturates in MEASURE
    lvl_sig = 1'b0;
    repeat (6) tick();
    do_start();
    repeat (5) tick();
    lvl_sig = 1'b1;
    wait_valid("ovf_meas", 300);
    chk_eq("ovf_meas_ovf", {31'd0, overflow}, 32'd1);
    chk_eq("ovf_meas_period", {24'd0, period}, 32'd255);
    chk_eq("ovf_meas_high", {24'd0, high_time}, 32'd0);
    handshake("ovf_meas");

    // Backpressure while sig_in keeps toggling, with a start pulse during HOLD
    start_wave(4, 4, 1'b0);
    do_start();
    wait_valid("bp", 60);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      start = 1'b0;
      chk_eq("bp_valid", {31'd0, meas_valid}, 32'd1);
      chk_eq("bp_period", {24'd0, period}, 32'd8);
      chk_eq("bp_high", {24'd0, high_time}, 32'd4);
    end
    start = 1'b1;
    meas_ready = 1'b1;
    tick();
    start = 1'b0;
    meas_ready = 1'b0;
    chk_eq("bp_hs_busy", {31'd0, busy}, 32'd0);
    tick();
    chk_eq("bp_start_ignored", {31'd0, busy}, 32'd0);
    chk_eq("bp_period_kept", {24'd0, period}, 32'd8);

    // Asynchronous reset in the middle of MEASURE
    start_wave(4, 4, 1'b0);
    do_start();
    repeat (6) tick();
    chk_eq("mid_busy", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_busy", {31'd0, busy}, 32'd0);
    chk_eq("arst_valid", {31'd0, meas_valid}, 32'd0);
    chk_eq("arst_period", {24'd0, period}, 32'd0);
    chk_eq("arst_high", {24'd0, high_time}, 32'd0);
    chk_eq("arst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk_eq("arst_idle", {31'd0, busy}, 32'd0);
    start_wave(4, 4, 1'b0);
    do_start();
    wait_valid("after_rst", 60);
    chk_eq("after_rst_period", {24'd0, period}, 32'd8);
    chk_eq("after_rst_high", {24'd0, high_time}, 32'd4);
    handshake("after_rst");

    // Glitches inside the high phase of a half-period-10 wave
    start_wave(10, 10, 1'b1);
    do_start();
    wait_valid("glitch", 120);
`ifdef SIG_DEGLITCH_EN
    chk_eq("glitch_period", {24'd0, period}, 32'd20);
    chk_eq("glitch_high", {24'd0, high_time}, 32'd10);
`else
    chk_eq("glitch_high_short", {31'd0, (high_time < 8'd10)}, 32'd1);
`endif
    handshake("glitch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
